// File: rtl/waveform_sequencer.sv
// Steps the signal generator through a programmed waveform table, switching steps only at DDS phase wrap.
// Optional SEQ_LOOP_EN: adds a per-step loop bit so the sequence restarts at step 0 after the final step.
module waveform_sequencer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int PHASE_WIDTH = 16,
  parameter int AMP_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]  cfg_wr_addr,
`ifdef SEQ_LOOP_EN
  input  logic [4+AMP_WIDTH+CNT_WIDTH:0]   cfg_wr_data,
`else
  input  logic [4+AMP_WIDTH+CNT_WIDTH-1:0] cfg_wr_data,
`endif
  input  logic [ADDR_WIDTH-1:0]  last_step,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] s_axis_tdata_phase,
  input  logic                   s_axis_tvalid_phase,
  output logic [3:0]             signal_type,
  output logic [AMP_WIDTH-1:0]   amplitude,
  output logic [ADDR_WIDTH-1:0]  step_idx,
  output logic                   busy,
  output logic                   done
);

`ifdef SEQ_LOOP_EN
  localparam int DW = 1 + 4 + AMP_WIDTH + CNT_WIDTH;
`else
  localparam int DW = 4 + AMP_WIDTH + CNT_WIDTH;
`endif
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_STOPPING} state_t;

  state_t                 r_state, w_state_nxt;
  logic [DW-1:0]          r_table [0:DEPTH-1];
  logic [PHASE_WIDTH-1:0] r_prev_phase;
  logic                   r_have_prev;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]  r_last, w_last_nxt;
  logic                   r_stop_pend, w_stop_pend_nxt;
  logic [3:0]             r_type, w_type_nxt;
  logic [AMP_WIDTH-1:0]   r_amp, w_amp_nxt;
  logic [ADDR_WIDTH-1:0]  r_idx, w_idx_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
`ifdef SEQ_LOOP_EN
  logic                   r_loop, w_loop_nxt;
`endif

  logic                   w_wrap;
  logic [ADDR_WIDTH-1:0]  w_rd_addr;
  logic [DW-1:0]          w_rd_word;
  logic [CNT_WIDTH-1:0]   w_rd_per;
  logic [CNT_WIDTH-1:0]   w_rd_cnt;

  // The first valid sample after IDLE only primes r_prev_phase, so it can never be a wrap.
  assign w_wrap = s_axis_tvalid_phase && r_have_prev && (s_axis_tdata_phase < r_prev_phase);

  // In RUN with steps left the next step is fetched; otherwise (ARM, or looping) step 0.
  assign w_rd_addr = ((r_state == ST_RUN) && (r_idx < r_last)) ? (r_idx + ADDR_ONE)
                                                                : {ADDR_WIDTH{1'b0}};
  assign w_rd_word = r_table[w_rd_addr];
  assign w_rd_per  = w_rd_word[CNT_WIDTH-1:0];
  assign w_rd_cnt  = (w_rd_per == {CNT_WIDTH{1'b0}}) ? CNT_ONE : w_rd_per;

  assign signal_type = r_type;
  assign amplitude   = r_amp;
  assign step_idx    = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;

  // Step table write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      r_table[cfg_wr_addr] <= cfg_wr_data[DW-1:0];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_stop_pend_nxt = r_stop_pend;
    w_type_nxt      = r_type;
    w_amp_nxt       = r_amp;
    w_idx_nxt       = r_idx;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
`ifdef SEQ_LOOP_EN
    w_loop_nxt      = r_loop;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_ARM;
          w_last_nxt  = last_step;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_wrap) begin
          w_state_nxt = ST_RUN;
          w_type_nxt  = w_rd_word[CNT_WIDTH+AMP_WIDTH +: 4];
          w_amp_nxt   = w_rd_word[CNT_WIDTH +: AMP_WIDTH];
          w_idx_nxt   = w_rd_addr;
          w_cnt_nxt   = w_rd_cnt;
`ifdef SEQ_LOOP_EN
          w_loop_nxt  = w_rd_word[DW-1];
`endif
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt     = ST_STOPPING;
          w_stop_pend_nxt = 1'b1;
        end else if (w_wrap && (r_cnt != CNT_ONE)) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (w_wrap && ((r_idx < r_last)
`ifdef SEQ_LOOP_EN
                                || r_loop
`endif
                               )) begin
          w_type_nxt = w_rd_word[CNT_WIDTH+AMP_WIDTH +: 4];
          w_amp_nxt  = w_rd_word[CNT_WIDTH +: AMP_WIDTH];
          w_idx_nxt  = w_rd_addr;
          w_cnt_nxt  = w_rd_cnt;
`ifdef SEQ_LOOP_EN
          w_loop_nxt = w_rd_word[DW-1];
`endif
        end else if (w_wrap) begin
          w_state_nxt = ST_IDLE;
          w_type_nxt  = 4'd0;
          w_amp_nxt   = {AMP_WIDTH{1'b0}};
          w_idx_nxt   = {ADDR_WIDTH{1'b0}};
          w_cnt_nxt   = {CNT_WIDTH{1'b0}};
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STOPPING: begin
        if (w_wrap && r_stop_pend) begin
          w_state_nxt     = ST_IDLE;
          w_stop_pend_nxt = 1'b0;
          w_type_nxt      = 4'd0;
          w_amp_nxt       = {AMP_WIDTH{1'b0}};
          w_idx_nxt       = {ADDR_WIDTH{1'b0}};
          w_cnt_nxt       = {CNT_WIDTH{1'b0}};
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
        end else begin
          w_state_nxt = ST_STOPPING;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, output and phase-history registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CNT_WIDTH{1'b0}};
      r_last       <= {ADDR_WIDTH{1'b0}};
      r_stop_pend  <= 1'b0;
      r_type       <= 4'd0;
      r_amp        <= {AMP_WIDTH{1'b0}};
      r_idx        <= {ADDR_WIDTH{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_prev_phase <= {PHASE_WIDTH{1'b0}};
      r_have_prev  <= 1'b0;
`ifdef SEQ_LOOP_EN
      r_loop       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_type      <= w_type_nxt;
      r_amp       <= w_amp_nxt;
      r_idx       <= w_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
`ifdef SEQ_LOOP_EN
      r_loop      <= w_loop_nxt;
`endif
      if (r_state == ST_IDLE) begin
        r_have_prev <= 1'b0;
      end else if (s_axis_tvalid_phase) begin
        r_prev_phase <= s_axis_tdata_phase;
        r_have_prev  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Randomized bench for waveform_sequencer; a queue-of-periods model predicts outputs on every cycle.
module tb_waveform_sequencer;
`ifdef SEQ_LOOP_EN
  localparam int DW = 1 + 4 + 16 + 16;
`else
  localparam int DW = 4 + 16 + 16;
`endif

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [3:0]    cfg_wr_addr = 4'd0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic [3:0]    last_step = 4'd0;
  logic          start = 1'b0, stop = 1'b0;
  logic [15:0]   s_axis_tdata_phase = 16'd0;
  logic          s_axis_tvalid_phase = 1'b0;
  logic [3:0]    signal_type;
  logic [15:0]   amplitude;
  logic [3:0]    step_idx;
  logic          busy, done;

  waveform_sequencer dut (
    .clk(clk), .aresetn(aresetn), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .last_step(last_step), .start(start), .stop(stop),
    .s_axis_tdata_phase(s_axis_tdata_phase), .s_axis_tvalid_phase(s_axis_tvalid_phase),
    .signal_type(signal_type), .amplitude(amplitude), .step_idx(step_idx),
    .busy(busy), .done(done)
  );

  always #4 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] ph = 16'd0;

  // Reference model: a sequence is a queue of remaining periods of the current step.
  logic [DW-1:0] m_tab [16];
  logic [23:0]   m_q [$];
  logic          m_armed = 1'b0, m_stop = 1'b0, m_have = 1'b0, m_loop = 1'b0;
  logic [15:0]   m_prev = 16'd0;
  logic [3:0]    m_last = 4'd0, m_cur = 4'd0;
  logic [3:0]    e_type = 4'd0;
  logic [15:0]   e_amp = 16'd0;
  logic [3:0]    e_idx = 4'd0;
  logic          e_busy = 1'b0, e_done = 1'b0;

  function automatic logic [25:0] act_v();
    return {busy, done, signal_type, amplitude, step_idx};
  endfunction
  function automatic logic [25:0] exp_v();
    return {e_busy, e_done, e_type, e_amp, e_idx};
  endfunction

  task automatic show_next();
    logic [23:0] v;
    v = m_q.pop_front();
    e_type = v[23:20]; e_amp = v[19:4]; e_idx = v[3:0];
  endtask

  task automatic load_step(input logic [3:0] k);
    logic [DW-1:0] w;
    int p;
    w = m_tab[k];
    p = int'(w[15:0]);
    if (p == 0) p = 1;
    m_q.delete();
    for (int i = 0; i < p; i++) m_q.push_back({w[35:32], w[31:16], k});
    m_cur = k;
`ifdef SEQ_LOOP_EN
    m_loop = w[DW-1];
`endif
    show_next();
  endtask

  task automatic end_seq(input logic with_done);
    m_q.delete();
    m_armed = 1'b0; m_stop = 1'b0;
    e_busy = 1'b0; e_done = with_done;
    e_type = 4'd0; e_amp = 16'd0; e_idx = 4'd0;
  endtask

  task automatic model_edge();
    logic b0, wrap;
    if (!aresetn) begin
      end_seq(1'b0);
      m_have = 1'b0; m_prev = 16'd0; m_loop = 1'b0;
      return;
    end
    b0 = e_busy;
    wrap = b0 && s_axis_tvalid_phase && m_have && (s_axis_tdata_phase < m_prev);
    e_done = 1'b0;
    if (!b0) begin
      if (start && !stop) begin e_busy = 1'b1; m_armed = 1'b1; m_last = last_step; end
    end else if (m_armed) begin
      if (stop) end_seq(1'b1);
      else if (wrap) begin m_armed = 1'b0; load_step(4'd0); end
    end else if (m_stop) begin
      if (wrap) end_seq(1'b1);
    end else if (stop) begin
      m_stop = 1'b1;
    end else if (wrap) begin
      if (m_q.size() > 0) show_next();
      else if (m_cur < m_last) load_step(m_cur + 4'd1);
      else if (m_loop) load_step(4'd0);
      else end_seq(1'b1);
    end
    if (!b0) m_have = 1'b0;
    else if (s_axis_tvalid_phase) begin m_have = 1'b1; m_prev = s_axis_tdata_phase; end
    if (cfg_wr_en) m_tab[cfg_wr_addr] = cfg_wr_data;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic phase_tick(input logic [15:0] incr, input int vpct);
    s_axis_tvalid_phase = ($urandom_range(99) < vpct);
    if (s_axis_tvalid_phase) begin ph = ph + incr; s_axis_tdata_phase = ph; end
    else s_axis_tdata_phase = 16'($urandom);
    tick();
  endtask

  task automatic write_step(input logic [3:0] a, input logic [3:0] t, input logic [15:0] amp,
                            input logic [15:0] per, input logic lp);
    cfg_wr_en = 1'b1; cfg_wr_addr = a;
`ifdef SEQ_LOOP_EN
    cfg_wr_data = {lp, t, amp, per};
`else
    cfg_wr_data = {t, amp, per};
    if (lp) cfg_wr_data = {t, amp, per};
`endif
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; tick(); tick();
    total++;
    if (act_v() !== 26'd0) begin bad++; $display("FAIL reset_state act=%h exp=%h", act_v(), 26'd0); end
    aresetn = 1'b1;
    for (int i = 0; i < 16; i++) write_step(4'(i), 4'd0, 16'd0, 16'd1, 1'b0);
    total++;
    if (act_v() !== exp_v()) begin bad++; $display("FAIL reset_idle act=%h exp=%h", act_v(), exp_v()); end
  endtask

  task automatic test_single();
    int dn = 0; bit fin = 0;
    write_step(4'd0, 4'd0, 16'h4000, 16'd2, 1'b0);
    last_step = 4'd0; ph = 16'd0; s_axis_tdata_phase = ph; s_axis_tvalid_phase = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy act=%b exp=1", busy); end
    for (int c = 0; c < 200 && !fin; c++) begin
      phase_tick(16'h1000, 100);
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL single_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (done) dn++;
      if (dn > 0 && !e_busy) fin = 1;
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL single_done_count act=%0d exp=1", dn); end
  endtask

  task automatic test_multi();
    bit fin = 0;
    write_step(4'd0, 4'd0, 16'h1111, 16'd1, 1'b0);
    write_step(4'd1, 4'd2, 16'h2222, 16'd3, 1'b0);
    write_step(4'd2, 4'd3, 16'h3333, 16'd0, 1'b0);
    last_step = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      phase_tick(16'($urandom_range(16'h0800, 16'h3000)), 80);
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL multi_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (!e_busy) fin = 1;
    end
    total++;
    if (!fin) begin bad++; $display("FAIL multi_timeout act=busy exp=idle"); end
  endtask

  task automatic test_stop();
    bit stopped = 0, fin = 0; int dn = 0;
    write_step(4'd0, 4'd1, 16'h7777, 16'd5, 1'b0);
    last_step = 4'd0; ph = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (!stopped && e_busy && !m_armed && ph == 16'h7000) begin stop = 1'b1; stopped = 1; end
      phase_tick(16'h1000, 100);
      stop = 1'b0;
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL stop_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (done) dn++;
      if (stopped && !e_busy) fin = 1;
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL stop_done_count act=%0d exp=1", dn); end
  endtask

  task automatic test_start_stop();
    bit fin = 0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL startstop_busy act=%b exp=0", busy); end
    stop = 1'b1; tick(); stop = 1'b0;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL idle_stop_done act=%b exp=0", done); end
    write_step(4'd0, 4'd2, 16'h0AAA, 16'd2, 1'b0);
    write_step(4'd1, 4'd1, 16'h0BBB, 16'd2, 1'b0);
    last_step = 4'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 800 && !fin; c++) begin
      start = ($urandom_range(9) == 0);
      last_step = 4'($urandom);
      phase_tick(16'h1800, 90);
      start = 1'b0;
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL busystart_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (!e_busy) fin = 1;
    end
  endtask

  task automatic test_gap();
    bit fin = 0, gapped = 0;
    write_step(4'd0, 4'd3, 16'h5A5A, 16'd4, 1'b0);
    last_step = 4'd0; ph = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (!gapped && e_busy && !m_armed && ph == 16'h8000) begin
        gapped = 1;
        for (int g = 0; g < 10; g++) begin
          s_axis_tvalid_phase = 1'b0; s_axis_tdata_phase = 16'h0010;
          tick();
          total++;
          if (act_v() !== exp_v()) begin bad++; $display("FAIL gap_cyc%0d act=%h exp=%h", g, act_v(), exp_v()); end
        end
      end
      phase_tick(16'h1000, 100);
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL gapseq_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (!e_busy) fin = 1;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 16; i++)
        write_step(4'(i), 4'($urandom), 16'($urandom), 16'($urandom_range(2)), 1'($urandom));
      last_step = 4'($urandom);
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        aresetn = ($urandom_range(299) != 0);
        start = ($urandom_range(49) == 0);
        stop = ($urandom_range(99) == 0);
        last_step = 4'($urandom);
        cfg_wr_en = ($urandom_range(19) == 0);
        cfg_wr_addr = 4'($urandom);
        cfg_wr_data = DW'({$urandom, $urandom}) & ~(DW'(16'hFFFC));
        phase_tick(16'($urandom_range(16'h0800, 16'h6000)), 75);
        aresetn = 1'b1; start = 1'b0; stop = 1'b0; cfg_wr_en = 1'b0;
        total++;
        if (act_v() !== exp_v()) begin bad++; $display("FAIL rand%0d_cyc%0d act=%h exp=%h", s, c, act_v(), exp_v()); end
      end
      stop = 1'b1; tick(); stop = 1'b0;
      for (int c = 0; c < 100 && e_busy; c++) phase_tick(16'h2000, 100);
    end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    int dn = 0, wraps20 = 0; logic [3:0] pidx = 4'd0; bit fin = 0;
    write_step(4'd0, 4'd0, 16'h1000, 16'd1, 1'b0);
    write_step(4'd1, 4'd2, 16'h2000, 16'd2, 1'b0);
    write_step(4'd2, 4'd3, 16'h3000, 16'd1, 1'b1);
    last_step = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      phase_tick(16'h1000, 100);
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL loop_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (done) dn++;
      if (pidx == 4'd2 && step_idx == 4'd0) wraps20++;
      pidx = step_idx;
    end
    total++;
    if (dn !== 0 || wraps20 < 2) begin bad++; $display("FAIL loop_nodone act=%0d/%0d exp=0/>=2", dn, wraps20); end
    stop = 1'b1; tick(); stop = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      phase_tick(16'h1000, 100);
      total++;
      if (act_v() !== exp_v()) begin bad++; $display("FAIL loopstop_cyc%0d act=%h exp=%h", c, act_v(), exp_v()); end
      if (done) dn++;
      if (!e_busy) fin = 1;
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL loop_stop_done act=%0d exp=1", dn); end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single();
    test_multi();
    test_stop();
    test_start_stop();
    test_gap();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
